// File: rtl/deserializer_if.sv
// Bus between a serial source and the deserializer: the serial bit stream in,
// and the rebuilt parallel word with its length field out.
interface deserializer_if;
    logic        ser_data_i;
    logic        ser_data_val_i;
    logic [15:0] deser_data_o;
    logic [3:0]  deser_data_mod_o;
    logic        deser_data_val_o;

    modport master (
        output ser_data_i,
        output ser_data_val_i,
        input  deser_data_o,
        input  deser_data_mod_o,
        input  deser_data_val_o
    );

    modport slave (
        input  ser_data_i,
        input  ser_data_val_i,
        output deser_data_o,
        output deser_data_mod_o,
        output deser_data_val_o
    );
endinterface

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel converter: one left-aligned 16-bit word per burst.
// Optional macro DESERIALIZER_DROP_SHORT_EN discards bursts of 1 or 2 bits.
module deserializer (
    input  logic           clk_i,
    input  logic           srst_i,
    deserializer_if.slave  bus
);
    logic [3:0]  r_cnt;
    logic [15:0] r_shreg;
    logic        r_active;
    logic [15:0] r_data;
    logic [3:0]  r_mod;
    logic        r_val;

    logic [15:0] w_word;
    logic        w_emit_partial;

    // Assembly word after this edge's bit lands; a burst's first bit also clears the rest.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bit
            localparam logic [3:0] BIT_CNT = 4'(15 - gi);
            assign w_word[gi] = (r_cnt == BIT_CNT) ? bus.ser_data_i
                              : ((r_cnt == 4'd0) ? 1'b0 : r_shreg[gi]);
        end
    endgenerate

`ifdef DESERIALIZER_DROP_SHORT_EN
    assign w_emit_partial = (r_cnt >= 4'd3);
`else
    assign w_emit_partial = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_cnt    <= 4'd0;
            r_shreg  <= 16'h0000;
            r_active <= 1'b0;
            r_data   <= 16'h0000;
            r_mod    <= 4'd0;
            r_val    <= 1'b0;
        end else begin
            r_val <= 1'b0;
            if (bus.ser_data_val_i) begin
                r_shreg <= w_word;
                if (r_cnt == 4'd15) begin
                    r_data   <= w_word;
                    r_mod    <= 4'd0;
                    r_val    <= 1'b1;
                    r_cnt    <= 4'd0;
                    r_active <= 1'b0;
                end else begin
                    r_cnt    <= r_cnt + 4'd1;
                    r_active <= 1'b1;
                end
            end else if (r_active) begin
                if (w_emit_partial) begin
                    r_data <= r_shreg;
                    r_mod  <= r_cnt;
                    r_val  <= 1'b1;
                end
                r_cnt    <= 4'd0;
                r_active <= 1'b0;
            end
        end
    end

    assign bus.deser_data_o     = r_data;
    assign bus.deser_data_mod_o = r_mod;
    assign bus.deser_data_val_o = r_val;
endmodule

// File: tb/tb_deserializer.sv
// Directed and randomized bench for deserializer, checked cycle by cycle against
// a queue-based burst model that packs each burst into a left-aligned word.
module tb_deserializer;
    logic clk = 1'b0;
    logic srst;

    deserializer_if bus ();

    deserializer dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    bit          q_bits[$];
    logic        exp_val;
    logic [15:0] exp_data = 16'h0000;
    logic [3:0]  exp_mod  = 4'd0;

    logic [15:0] got_data[$];
    logic [3:0]  got_mod[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    function automatic logic [15:0] pack_burst();
        logic [15:0] w;
        w = 16'h0000;
        for (int i = 0; i < q_bits.size(); i++) w[15-i] = q_bits[i];
        return w;
    endfunction

    // One clock: drive inputs, predict outputs from the burst model, compare after the edge.
    task automatic step(input logic rst, input logic v, input logic b);
        srst               = rst;
        bus.ser_data_val_i = v;
        bus.ser_data_i     = b;
        exp_val            = 1'b0;
        if (rst) begin
            q_bits.delete();
            exp_data = 16'h0000;
            exp_mod  = 4'd0;
        end else if (v) begin
            q_bits.push_back(b);
            if (q_bits.size() == 16) begin
                exp_val  = 1'b1;
                exp_data = pack_burst();
                exp_mod  = 4'd0;
                q_bits.delete();
            end
        end else if (q_bits.size() > 0) begin
`ifdef DESERIALIZER_DROP_SHORT_EN
            if (q_bits.size() >= 3)
`endif
            begin
                exp_val  = 1'b1;
                exp_data = pack_burst();
                exp_mod  = 4'(q_bits.size());
            end
            q_bits.delete();
        end
        @(posedge clk);
        #1;
        check("val",  32'(bus.deser_data_val_o), 32'(exp_val));
        check("data", 32'(bus.deser_data_o),     32'(exp_data));
        check("mod",  32'(bus.deser_data_mod_o), 32'(exp_mod));
        if (bus.deser_data_val_o === 1'b1) begin
            got_data.push_back(bus.deser_data_o);
            got_mod.push_back(bus.deser_data_mod_o);
            $display("t=%0t pulse data=%h mod=%0d", $time, bus.deser_data_o, bus.deser_data_mod_o);
        end
    endtask

    task automatic send_bits(input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) step(1'b0, 1'b1, w[15-i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_pulse(input string tag, input int idx, input logic [15:0] d, input logic [3:0] m);
        if (idx < got_data.size()) begin
            check({tag, "_data"}, 32'(got_data[idx]), 32'(d));
            check({tag, "_mod"},  32'(got_mod[idx]),  32'(m));
        end else begin
            check({tag, "_present"}, 32'(got_data.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        logic [15:0] rnd_word;
        int          len;

        srst               = 1'b1;
        bus.ser_data_val_i = 1'b0;
        bus.ser_data_i     = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        check("reset_data", 32'(bus.deser_data_o),     32'h0);
        check("reset_mod",  32'(bus.deser_data_mod_o), 32'h0);
        check("reset_val",  32'(bus.deser_data_val_o), 32'h0);
        idle(2);

        // Full word
        got_data.delete(); got_mod.delete();
        send_bits(16'hA5C3, 16);
        idle(3);
        check("full_count", 32'(got_data.size()), 32'd1);
        check_pulse("full", 0, 16'hA5C3, 4'd0);

        // 5-bit burst 10111
        got_data.delete(); got_mod.delete();
        send_bits(16'hB800, 5);
        idle(3);
        check("p5_count", 32'(got_data.size()), 32'd1);
        check_pulse("p5", 0, 16'hB800, 4'd5);

        // 32-bit continuous burst
        got_data.delete(); got_mod.delete();
        send_bits(16'h1234, 16);
        send_bits(16'hFFFF, 16);
        idle(3);
        check("c32_count", 32'(got_data.size()), 32'd2);
        check_pulse("c32_a", 0, 16'h1234, 4'd0);
        check_pulse("c32_b", 1, 16'hFFFF, 4'd0);

        // Two bursts separated by a single-cycle gap
        got_data.delete(); got_mod.delete();
        send_bits(16'hE000, 3);
        idle(1);
        send_bits(16'h5000, 4);
        idle(3);
        check("gap_count", 32'(got_data.size()), 32'd2);
        check_pulse("gap_a", 0, 16'hE000, 4'd3);
        check_pulse("gap_b", 1, 16'h5000, 4'd4);

        // 2-bit burst
        got_data.delete(); got_mod.delete();
        send_bits(16'hC000, 2);
        idle(3);
`ifdef DESERIALIZER_DROP_SHORT_EN
        check("p2_count", 32'(got_data.size()), 32'd0);
        check("p2_hold",  32'(bus.deser_data_o), 32'h5000);
`else
        check("p2_count", 32'(got_data.size()), 32'd1);
        check_pulse("p2", 0, 16'hC000, 4'd2);
`endif

        // Reset mid-burst
        got_data.delete(); got_mod.delete();
        send_bits(16'hAAAA, 7);
        step(1'b1, 1'b0, 1'b0);
        check("rst_mid_data", 32'(bus.deser_data_o), 32'h0);
        send_bits(16'hFFFF, 16);
        idle(3);
        check("rst_mid_count", 32'(got_data.size()), 32'd1);
        check_pulse("rst_mid", 0, 16'hFFFF, 4'd0);

        // Random bursts, gaps and occasional resets
        for (int n = 0; n < 80; n++) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 199) == 0) step(1'b1, 1'b0, 1'b0);
                else step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            end
            rnd_word = 16'($urandom);
            idle(int'(rnd_word[1:0]) + 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/deserializer.md
# deserializer

Receive-side counterpart of the team's serializer. It captures an MSB-first serial bit stream qualified by a valid strobe and rebuilds each burst into a left-aligned 16-bit word. Alongside the word it reports the burst length using the serializer's `data_mod` encoding. It sits at the sink end of any serial link driven by the serializer and presents one parallel word per burst to downstream logic.

## Interface
- No parameters. Word width is fixed at 16 and the length field at 4 bits.
- `clk_i`  input  1  single clock; all logic is on the rising edge.
- `srst_i`  input  1  synchronous reset, active-high.
- `ser_data_i`  input  1  serial data bit, MSB first; sampled only when `ser_data_val_i`=1.
- `ser_data_val_i`  input  1  bit qualifier; a contiguous high run forms one burst.
- `deser_data_o`  output  16  reconstructed word, left-aligned: first bit in [15]; unreceived low bits are 0.
- `deser_data_mod_o`  output  4  number of valid bits, 1..15; 0 means 16.
- `deser_data_val_o`  output  1  one-cycle pulse qualifying `deser_data_o` and `deser_data_mod_o`.

## Operation
- **Internal state:**
  - bit counter `cnt` (0..15);
  - 16-bit assembly register `shreg`;
  - flag `active`, set while a burst is in progress.
- **Edge with `ser_data_val_i`=1:**
  - `shreg[15-cnt]` <= `ser_data_i`.
  - If `cnt`=0, all other `shreg` bits are cleared on the same edge.
  - `cnt` increments and `active` <= 1.
- **Word complete** (the edge that samples the 16th bit, `cnt`=15):
  - `deser_data_o` <= completed word, `deser_data_mod_o` <= 0, `deser_data_val_o` <= 1.
  - `cnt` wraps to 0 and `active` <= 0.
  - If `ser_data_val_i` stays high, the next bit starts a new word with no gap. Bursts longer than 16 bits therefore split into consecutive 16-bit words.
- **Burst end** (first edge with `ser_data_val_i`=0 while `active`=1, so `cnt` is 1..15):
  - `deser_data_o` <= `shreg`, `deser_data_mod_o` <= `cnt`, `deser_data_val_o` <= 1.
  - `cnt` <= 0 and `active` <= 0.
- **Idle:** `ser_data_val_i`=0 with `active`=0 produces no output.
- **Output hold:** `deser_data_o` and `deser_data_mod_o` hold their last value between pulses. `deser_data_val_o` is high for exactly one cycle per word.
- **Back-to-back boundary:** a single-cycle low gap on `ser_data_val_i` terminates a burst. The following high starts a new burst, and its first bit is captured on that edge.
- **No backpressure:** downstream must accept every pulse.

## Timing
- **Reset values** (all outputs and state registered): `deser_data_o`=0x0000, `deser_data_mod_o`=0, `deser_data_val_o`=0, `cnt`=0, `active`=0, `shreg`=0.
- **Reset mid-burst:** the partial word is discarded and no pulse is emitted. The first valid bit after reset deasserts is bit 15 of a new word.
- **Full word latency:** `deser_data_val_o` is high in the cycle after the edge that samples bit 16.
- **Partial burst latency:** `deser_data_val_o` is high in the cycle after the first low-`ser_data_val_i` edge, i.e. 2 cycles after the last bit is sampled.
- **16th bit followed by `ser_data_val_i` falling:** exactly one pulse (mod 0); no second pulse for the empty remainder.
- **Throughput:** one bit per clock, sustained indefinitely.
- **Serializer pairing:** a serializer burst of length `data_mod` arrives as one pulse with `deser_data_mod_o`=`data_mod`.

## Configuration
- **Macro:** `DESERIALIZER_DROP_SHORT_EN`.
- **Defined:**
  - Partial bursts of 1 or 2 bits are discarded silently: no pulse, outputs unchanged, counter cleared.
  - This matches the serializer's rejection of `data_mod` 1 and 2.
- **Undefined:** such bursts are reported normally with `deser_data_mod_o`=1 or 2.
- **Unaffected by the macro:** bursts of 3..16 bits.

## Test plan
- **Full word:** 16 bits of 0xA5C3 MSB-first, `ser_data_val_i` high for 16 cycles -> one pulse, `deser_data_o`=0xA5C3, `deser_data_mod_o`=0, one cycle after the last bit.
- **5-bit burst:** bits 1,0,1,1,1 then `ser_data_val_i` low -> one pulse 2 cycles after the last bit, `deser_data_o`=0xB800, `deser_data_mod_o`=5.
- **32-bit continuous burst:** 0x1234 then 0xFFFF -> two pulses 16 cycles apart, values 0x1234 then 0xFFFF, both mod 0, no extra pulse at burst end.
- **Two bursts split by a 1-cycle gap:** 3 bits 111, gap, 4 bits 0101 -> pulses 0xE000/mod 3, then 0x5000/mod 4; the second word's low bits are 0 with no residue from the first.
- **2-bit burst:** bits 11 -> macro undefined: 0xC000/mod 2. Macro defined: no pulse, and outputs keep their previous value.
- **Reset mid-burst:** `srst_i` high for 1 cycle after 7 bits, then 16 bits of 0xFFFF -> all outputs 0 after reset, then a single pulse 0xFFFF/mod 0 with no partial word emitted.
